// File: rtl/alu_share_if.sv
// ---------------------------------------------------------------------------
// alu_share_if
// Bundles every signal between the execute-stage requesters, the shared
// combinational ALU and the alu_share_arbiter.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   OPW      ALU op-code width (op 8 = UNKNOWN)
//   DW       operand width (bit 32 is the SLTU extension bit)
//
// Signals
//   req_valid / req_ready      per-requester handshake, one bit per requester
//   req_in_a / req_in_b        packed operands, slice i = [i*DW +: DW]
//   req_alu_op                 packed op codes, slice i = [i*OPW +: OPW]
//   alu_in_a / alu_in_b/alu_op granted operation presented to the ALU
//   alu_result                 combinational ALU answer, same cycle
//   rsp_valid / rsp_ready      one-hot result handshake back to the owner
//   rsp_result / rsp_illegal   registered result and UNKNOWN-op flag
//
// Modports
//   slave   the arbiter side
//   master  the environment side (requesters plus the ALU itself)
// ---------------------------------------------------------------------------
interface alu_share_if #(
   parameter int NUM_REQ = 3,
   parameter int OPW     = 5,
   parameter int DW      = 33
) ();

   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*DW-1:0]  req_in_a;
   logic [NUM_REQ*DW-1:0]  req_in_b;
   logic [NUM_REQ*OPW-1:0] req_alu_op;

   logic [DW-1:0]          alu_in_a;
   logic [DW-1:0]          alu_in_b;
   logic [OPW-1:0]         alu_op;
   logic [31:0]            alu_result;

   logic [NUM_REQ-1:0]     rsp_valid;
   logic [NUM_REQ-1:0]     rsp_ready;
   logic [31:0]            rsp_result;
   logic                   rsp_illegal;

   modport slave (
      input  req_valid, req_in_a, req_in_b, req_alu_op, alu_result, rsp_ready,
      output req_ready, alu_in_a, alu_in_b, alu_op, rsp_valid, rsp_result, rsp_illegal
   );

   modport master (
      output req_valid, req_in_a, req_in_b, req_alu_op, alu_result, rsp_ready,
      input  req_ready, alu_in_a, alu_in_b, alu_op, rsp_valid, rsp_result, rsp_illegal
   );

endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between NUM_REQ execute-stage requesters
// (integer execute, branch compare, load/store address generation).
// A round-robin scan picks one valid requester per cycle whenever the
// one-entry result stage can take a new entry; the granted operands are
// steered to the ALU and the answer is captured into the result stage,
// which returns it to its owner with a one-hot valid/ready handshake.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous, active-low reset
//   bus      alu_share_if.slave: request handshakes and operands, ALU
//            operand/op outputs and result input, response handshake
//
// Notes
//   - req_ready is combinational from req_valid/rsp_ready (same-cycle grant).
//   - A result stage whose owner drains in the same cycle can accept a new
//     operation, so a continuously draining owner sees 1 op/cycle.
//   - Op code 8 is UNKNOWN: the response carries rsp_illegal=1 and result 0.
//   - After reset release nothing is granted until the first clock edge.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int OPW     = 5,
   parameter int DW      = 33
) (
   input  logic        clk,
   input  logic        reset_n,
   alu_share_if.slave  bus
);

   localparam int             PTRW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [OPW-1:0] OP_UNKNOWN = OPW'(8);
   localparam logic [PTRW-1:0] LAST_IDX  = PTRW'(NUM_REQ - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } stage_t;

   stage_t              stage;
   logic [PTRW-1:0]     owner;
   logic [PTRW-1:0]     rr_ptr;
   logic                armed;
   logic [NUM_REQ-1:0]  rsp_valid_q;
   logic [31:0]         rsp_result_q;
   logic                rsp_illegal_q;

   int                  scan_idx;
   logic                any_valid;
   logic [PTRW-1:0]     grant_idx;
   logic                can_accept;
   logic                grant;
   logic [PTRW-1:0]     next_ptr;
   logic [NUM_REQ-1:0]  ready_vec;
   logic [DW-1:0]       mux_a;
   logic [DW-1:0]       mux_b;
   logic [OPW-1:0]      mux_op;
   logic                op_illegal;

   // Round-robin scan: walk the requesters starting at rr_ptr, wrapping at
   // NUM_REQ, and remember the first one presenting an operation.
   always_comb begin
      scan_idx  = 0;
      any_valid = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!any_valid && bus.req_valid[scan_idx]) begin
            any_valid = 1'b1;
            grant_idx = PTRW'(scan_idx);
         end
      end
   end

   // The stage can take a new entry when empty, or when its current owner
   // consumes the held result this very cycle. armed holds off any grant
   // until the first edge after reset release.
   always_comb begin
      can_accept = (stage == EMPTY) || bus.rsp_ready[owner];
      grant      = armed && can_accept && any_valid;
   end

   // Steer the granted slice to the ALU. With no grant the ALU sees 0/0/8
   // so stale operands never leak through.
   always_comb begin
      ready_vec = '0;
      mux_a     = '0;
      mux_b     = '0;
      mux_op    = OP_UNKNOWN;
      if (grant) begin
         ready_vec[grant_idx] = 1'b1;
         mux_a  = bus.req_in_a[int'(grant_idx) * DW +: DW];
         mux_b  = bus.req_in_b[int'(grant_idx) * DW +: DW];
         mux_op = bus.req_alu_op[int'(grant_idx) * OPW +: OPW];
      end
      op_illegal = (mux_op == OP_UNKNOWN);
      next_ptr   = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTRW'(1);
   end

   // Result stage state machine. A grant always loads the stage (even over
   // a same-cycle drain); otherwise a drain by the owner empties it, and
   // any other case holds result, flag and owner. The pointer only moves
   // on a grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage         <= EMPTY;
         owner         <= '0;
         rr_ptr        <= '0;
         armed         <= 1'b0;
         rsp_valid_q   <= '0;
         rsp_result_q  <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (grant) begin
            stage         <= FULL;
            owner         <= grant_idx;
            rsp_valid_q   <= ready_vec;
            rsp_result_q  <= op_illegal ? 32'd0 : bus.alu_result;
            rsp_illegal_q <= op_illegal;
            rr_ptr        <= next_ptr;
         end else if ((stage == FULL) && bus.rsp_ready[owner]) begin
            stage       <= EMPTY;
            rsp_valid_q <= '0;
         end
      end
   end

   assign bus.req_ready   = ready_vec;
   assign bus.alu_in_a    = mux_a;
   assign bus.alu_in_b    = mux_b;
   assign bus.alu_op      = mux_op;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_illegal = rsp_illegal_q;

endmodule
